// File: rtl/video_timing_pkg.sv
// Shared 720p raster constants, counter types, pattern selects and colour-bar palette
// for the HDMI video source path.
package video_timing_pkg;

  localparam int unsigned H_ACTIVE_720 = 1280;
  localparam int unsigned H_FP_720     = 110;
  localparam int unsigned H_SYNC_720   = 40;
  localparam int unsigned H_BP_720     = 220;
  localparam int unsigned V_ACTIVE_720 = 720;
  localparam int unsigned V_FP_720     = 5;
  localparam int unsigned V_SYNC_720   = 5;
  localparam int unsigned V_BP_720     = 20;

  localparam int unsigned H_TOTAL_720 = H_ACTIVE_720 + H_FP_720 + H_SYNC_720 + H_BP_720;
  localparam int unsigned V_TOTAL_720 = V_ACTIVE_720 + V_FP_720 + V_SYNC_720 + V_BP_720;

  localparam int unsigned H_CNT_W = 11;
  localparam int unsigned V_CNT_W = 10;

  typedef logic [H_CNT_W-1:0] hcnt_t;
  typedef logic [V_CNT_W-1:0] vcnt_t;
  typedef logic [23:0]        rgb_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_WHITE = 2'd2,
    PAT_GRID  = 2'd3
  } pat_sel_e;

  localparam int unsigned BAR_W = 160;

  localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb_t BAR_GREEN   = 24'h00FF00;
  localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb_t BAR_RED     = 24'hFF0000;
  localparam rgb_t BAR_BLUE    = 24'h0000FF;
  localparam rgb_t BAR_BLACK   = 24'h000000;

  // Bar index by threshold comparison so no divider is inferred.
  function automatic logic [2:0] bar_index(input hcnt_t h);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (h >= hcnt_t'(BAR_W * i)) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic rgb_t bar_color(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster-position / pattern-select bundle between the timing core and the
// combinational pattern generator.
interface video_timing_gen_if import video_timing_pkg::*; ();
  hcnt_t    h_cnt;
  vcnt_t    v_cnt;
  pat_sel_e sel;
  rgb_t     rgb;

  modport master (output h_cnt, output v_cnt, output sel, input rgb);
  modport slave  (input h_cnt, input v_cnt, input sel, output rgb);
endinterface

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern source: raster position and select in, 24-bit RGB out.
module video_pattern_gen import video_timing_pkg::*; (
  video_timing_gen_if.slave pat
);

  always_comb begin
    pat.rgb = BAR_BLACK;
    case (pat.sel)
      PAT_BARS:  pat.rgb = bar_color(bar_index(pat.h_cnt));
      PAT_GRAD:  pat.rgb = {pat.h_cnt[10:3], pat.v_cnt[9:2], 8'h80};
      PAT_WHITE: pat.rgb = BAR_WHITE;
      PAT_GRID:  pat.rgb = ((pat.h_cnt[4:0] == '0) || (pat.v_cnt[4:0] == '0)) ? BAR_WHITE
                                                                              : BAR_BLACK;
      default:   pat.rgb = BAR_BLACK;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Pixel-clock raster generator: h/v counters, sync/de decode and registered test
// pattern, all outputs aligned with one cycle of latency to the counters.
module video_timing_gen import video_timing_pkg::*; #(
  parameter int unsigned H_ACTIVE = H_ACTIVE_720,
  parameter int unsigned H_FP     = H_FP_720,
  parameter int unsigned H_SYNC   = H_SYNC_720,
  parameter int unsigned H_BP     = H_BP_720,
  parameter int unsigned V_ACTIVE = V_ACTIVE_720,
  parameter int unsigned V_FP     = V_FP_720,
  parameter int unsigned V_SYNC   = V_SYNC_720,
  parameter int unsigned V_BP     = V_BP_720,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        pixelclk,
  input  logic        rst_n,
  input  logic [1:0]  pattern_sel,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  red_din,
  output logic [7:0]  green_din,
  output logic [7:0]  blue_din,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start
);

  localparam hcnt_t H_LAST = hcnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam hcnt_t H_ACT  = hcnt_t'(H_ACTIVE);
  localparam hcnt_t HS_BEG = hcnt_t'(H_ACTIVE + H_FP);
  localparam hcnt_t HS_END = hcnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam vcnt_t V_LAST = vcnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam vcnt_t V_ACT  = vcnt_t'(V_ACTIVE);
  localparam vcnt_t VS_BEG = vcnt_t'(V_ACTIVE + V_FP);
  localparam vcnt_t VS_END = vcnt_t'(V_ACTIVE + V_FP + V_SYNC);

  hcnt_t    h_cnt_q, h_cnt_d;
  vcnt_t    v_cnt_q, v_cnt_d;
  pat_sel_e sel_q, sel_d;
  logic     hsync_q, hsync_d;
  logic     vsync_q, vsync_d;
  logic     de_q, de_d;
  logic     fs_q, fs_d;
  rgb_t     rgb_q, rgb_d;
  hcnt_t    pix_x_q, pix_x_d;
  vcnt_t    pix_y_q, pix_y_d;
  logic     origin;

  video_timing_gen_if pif ();

  video_pattern_gen u_pattern (.pat(pif));

  assign origin = (h_cnt_q == '0) && (v_cnt_q == '0);
  // The select is taken at (0,0) and applied to that pixel too, so a whole frame uses one pattern.
  assign sel_d     = origin ? pat_sel_e'(pattern_sel) : sel_q;
  assign pif.h_cnt = h_cnt_q;
  assign pif.v_cnt = v_cnt_q;
  assign pif.sel   = sel_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end

    de_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
    fs_d    = origin;
    pix_x_d = de_d ? h_cnt_q : '0;
    pix_y_d = de_d ? v_cnt_q : '0;
    rgb_d   = de_d ? pif.rgb : '0;
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      sel_q   <= PAT_BARS;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      sel_q   <= sel_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      rgb_q   <= rgb_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign red_din     = rgb_q[23:16];
  assign green_din   = rgb_q[15:8];
  assign blue_din    = rgb_q[7:0];
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;

endmodule
